// File: rtl/result_buffer_if.sv
// Result handshake between a functional unit, its result buffer
// and one arbiter station slot.
interface result_buffer_if #(
   parameter int SIZE = 32
);
   logic            in_valid;
   logic [SIZE-1:0] in_value;
   logic            in_ready;
   logic            station_ready;
   logic [SIZE-1:0] station_value;
   logic            station_is_asserting;

   modport slave (
      input  in_valid,
      input  in_value,
      input  station_is_asserting,
      output in_ready,
      output station_ready,
      output station_value
   );

   modport master (
      output in_valid,
      output in_value,
      output station_is_asserting,
      input  in_ready,
      input  station_ready,
      input  station_value
   );
endinterface

// File: rtl/result_buffer.sv
// Per-unit FIFO of completed results feeding one arbiter station slot.
// Define RESULT_BUFFER_BYPASS_EN for a zero-latency path when empty.
module result_buffer #(
   parameter int SIZE  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   result_buffer_if.slave             bus,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [SIZE-1:0] mem [DEPTH];
   logic [PW-1:0]   rd;
   logic [PW-1:0]   wr;
   logic [CW-1:0]   count;

   logic empty;
   logic full;
   logic byp;
   logic push;
   logic pop;
   logic wr_en;
   logic rd_en;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

`ifdef RESULT_BUFFER_BYPASS_EN
   assign byp = empty && bus.in_valid && !flush;
`else
   assign byp = 1'b0;
`endif

   assign bus.in_ready      = !full && !flush;
   assign bus.station_ready = !empty || byp;
   assign occupancy         = count;

   always_comb begin
      bus.station_value = '0;
      if (byp)
         bus.station_value = bus.in_value;
      else if (!empty)
         bus.station_value = mem[rd];
   end

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.station_is_asserting && bus.station_ready;

   // A bypassed result that is granted is consumed without touching storage.
   assign wr_en = push && !(byp && bus.station_is_asserting);
   assign rd_en = pop && !empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (wr_en)
            wr <= nxt(wr);
         if (rd_en)
            rd <= nxt(rd);
         if (wr_en && !rd_en)
            count <= count + CW'(1);
         else if (rd_en && !wr_en)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && wr_en)
         mem[wr] <= bus.in_value;
   end
endmodule

// File: tb/tb_result_buffer.sv
// Randomized and directed checks of result_buffer at DEPTH 4 and 3
// against a queue-based reference model.
module tb_result_buffer;
`ifdef RESULT_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   logic flush;
   logic [2:0] occ4;
   logic [1:0] occ3;

   always #5 clock = ~clock;

   result_buffer_if #(.SIZE(32)) b4 ();
   result_buffer_if #(.SIZE(32)) b3 ();

   result_buffer #(.SIZE(32), .DEPTH(4)) u4 (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .bus       (b4.slave),
      .occupancy (occ4)
   );

   result_buffer #(.SIZE(32), .DEPTH(3)) u3 (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .bus       (b3.slave),
      .occupancy (occ3)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] q4 [$];
   logic [31:0] q3 [$];

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic expect_unit(input string tag, input int d,
                              input int n, input logic [31:0] head,
                              input logic v, input logic [31:0] val,
                              input logic fl, input logic rdy,
                              input logic srdy, input logic [31:0] sval,
                              input int occ);
      logic byp;
      logic [31:0] ev;
      byp = BYP && n == 0 && v && !fl;
      ev  = byp ? val : (n != 0 ? head : 32'h0);
      check({tag, ".in_ready"}, 64'(rdy), 64'(n != d && !fl));
      check({tag, ".station_ready"}, 64'(srdy), 64'(n != 0 || byp));
      check({tag, ".station_value"}, 64'(sval), 64'(ev));
      check({tag, ".occupancy"}, 64'(occ), 64'(n));
   endtask

   task automatic advance(input int d, input logic rst, input logic fl,
                          input logic v, input logic [31:0] val,
                          input logic g, inout logic [31:0] q [$]);
      int n;
      n = q.size();
      if (rst || fl) begin
         q.delete();
      end else if (!(BYP && n == 0 && v && g)) begin
         if (g && n > 0)
            void'(q.pop_front());
         if (v && n < d)
            q.push_back(val);
      end
   endtask

   task automatic step(input logic rst, input logic fl, input logic v,
                       input logic [31:0] val, input logic g,
                       input bit chk);
      @(negedge clock);
      reset = rst;
      flush = fl;
      b4.in_valid = v;
      b4.in_value = val;
      b4.station_is_asserting = g;
      b3.in_valid = v;
      b3.in_value = val;
      b3.station_is_asserting = g;
      #1;
      if (chk) begin
         expect_unit("d4", 4, q4.size(), q4.size() ? q4[0] : 32'h0,
                     v, val, fl, b4.in_ready, b4.station_ready,
                     b4.station_value, int'(occ4));
         expect_unit("d3", 3, q3.size(), q3.size() ? q3[0] : 32'h0,
                     v, val, fl, b3.in_ready, b3.station_ready,
                     b3.station_value, int'(occ3));
      end
      advance(4, rst, fl, v, val, g, q4);
      advance(3, rst, fl, v, val, g, q3);
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      b4.in_valid = 1'b0;
      b4.in_value = '0;
      b4.station_is_asserting = 1'b0;
      b3.in_valid = 1'b0;
      b3.in_value = '0;
      b3.station_is_asserting = 1'b0;

      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);

      // fill and block, then drain in order
      step(0, 0, 1, 32'h11, 0, 1);
      step(0, 0, 1, 32'h22, 0, 1);
      step(0, 0, 1, 32'h33, 0, 1);
      step(0, 0, 1, 32'h44, 0, 1);
      step(0, 0, 1, 32'h55, 0, 1);
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 0, 1, 1);

      // push and pop together at count 1
      step(0, 0, 1, 32'hA0, 0, 1);
      step(0, 0, 1, 32'hB0, 1, 1);
      step(0, 0, 0, 0, 0, 1);

      // wrap-around
      step(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++)
         step(0, 0, 1, 32'h100 + 32'(i), 1, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);

      // flush with entries and a push
      step(0, 0, 1, 32'h201, 0, 1);
      step(0, 0, 1, 32'h202, 0, 1);
      step(0, 0, 1, 32'h203, 0, 1);
      step(0, 1, 1, 32'h204, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // reset beats flush
      step(0, 0, 1, 32'h301, 0, 1);
      step(1, 1, 1, 32'h302, 1, 1);
      step(0, 0, 0, 0, 0, 1);

`ifdef RESULT_BUFFER_BYPASS_EN
      step(0, 0, 1, 32'h5A, 1, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 32'h5A, 0, 1);
      step(0, 0, 0, 0, 0, 1);
`endif

      for (int i = 0; i < 400; i++) begin
         logic r, f, v, g;
         r = ($urandom_range(0, 99) == 0);
         f = ($urandom_range(0, 49) == 0);
         v = ($urandom_range(0, 99) < 60);
         g = ($urandom_range(0, 99) < 45);
         step(r, f, v, $urandom, g, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
